// File: rtl/battle_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : battle_pkg
//  Description : Shared types, default constants and helpers for the battle
//                roll datapath (FSM state encoding, LFSR defaults, HP math).
//  Revision    : 1.0 - initial release
// ============================================================================
package battle_pkg;

   // Roll controller states
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SPIN  = 2'd1,
      APPLY = 2'd2,
      KO    = 2'd3
   } state_t;

   // Maximal-length 16-bit Galois LFSR defaults
   localparam logic [15:0] DEFAULT_SEED = 16'hACE1;
   localparam logic [15:0] DEFAULT_TAPS = 16'hB400;

   // Saturating subtract: never wraps below zero
   function automatic logic [31:0] hp_sat_sub(input logic [31:0] hp_v,
                                              input logic [31:0] dmg_v);
      return (hp_v > dmg_v) ? (hp_v - dmg_v) : 32'd0;
   endfunction

endpackage
`default_nettype wire

// File: rtl/battle_roll_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : battle_roll_unit_if
//  Description : Control/status bundle between a battle controller (master)
//                and the roll unit (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface battle_roll_unit_if #(
   parameter int RNG_W  = 16,
   parameter int ROLL_W = 4,
   parameter int HP_W   = 4
) ();
   logic              seed_load;
   logic [RNG_W-1:0]  seed;
   logic              roll_req;
   logic              roll_ready;
   logic [ROLL_W-1:0] threshold;
   logic [HP_W-1:0]   damage;
   logic              hp_reload;
   logic              roll_valid;
   logic [ROLL_W-1:0] roll_value;
   logic              hit;
   logic [HP_W-1:0]   hp;
   logic              ko;

   modport master (
      output seed_load, seed, roll_req, threshold, damage, hp_reload,
      input  roll_ready, roll_valid, roll_value, hit, hp, ko
   );

   modport slave (
      input  seed_load, seed, roll_req, threshold, damage, hp_reload,
      output roll_ready, roll_valid, roll_value, hit, hp, ko
   );
endinterface
`default_nettype wire

// File: rtl/galois_lfsr.sv
`default_nettype none
// ============================================================================
//  Module      : galois_lfsr
//  Description : Seedable right-shifting Galois LFSR. A zero load value is
//                replaced by SEED so the register can never lock up at zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module galois_lfsr
   import battle_pkg::*;
#(
   parameter int               RNG_W = 16,
   parameter logic [RNG_W-1:0] SEED  = RNG_W'(DEFAULT_SEED),
   parameter logic [RNG_W-1:0] TAPS  = RNG_W'(DEFAULT_TAPS)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             step,
   input  logic             load,
   input  logic [RNG_W-1:0] load_val,
   output logic [RNG_W-1:0] state
);

   logic [RNG_W-1:0] state_q;

   // Reset to SEED, load (zero mapped to SEED) has priority over stepping
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= SEED;
      end else if (load) begin
         state_q <= (load_val == '0) ? SEED : load_val;
      end else if (step) begin
         state_q <= (state_q >> 1) ^ (state_q[0] ? TAPS : '0);
      end
   end

   assign state = state_q;

endmodule
`default_nettype wire

// File: rtl/battle_roll_unit.sv
`default_nettype none
// ============================================================================
//  Module      : battle_roll_unit
//  Description : Dice roll and HP datapath. Spins an LFSR ROLL_W steps per
//                roll, compares against a threshold, applies saturating
//                damage to HP and flags KO at zero. Reload restores HP.
//  Revision    : 1.0 - initial release
// ============================================================================
module battle_roll_unit
   import battle_pkg::*;
#(
   parameter int               RNG_W   = 16,
   parameter int               ROLL_W  = 4,
   parameter int               HP_W    = 4,
   parameter int               HP_INIT = 9,
   parameter logic [RNG_W-1:0] SEED    = RNG_W'(DEFAULT_SEED),
   parameter logic [RNG_W-1:0] TAPS    = RNG_W'(DEFAULT_TAPS)
) (
   input  logic               clk,
   input  logic               reset,
   battle_roll_unit_if.slave  bus
);

   localparam int              CNT_W    = $clog2(ROLL_W) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ROLL_W - 1);
   localparam logic [HP_W-1:0]  HP_RESET = HP_W'(HP_INIT);

   state_t            state_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [ROLL_W-1:0] roll_value_q;
   logic              hit_q;
   logic              roll_valid_q;
   logic [HP_W-1:0]   hp_q;
   logic              ko_q;

   logic [RNG_W-1:0]  w_lfsr_state;
   logic              w_lfsr_step;
   logic              w_lfsr_load;
   logic              w_unused_lfsr;
   logic [ROLL_W-1:0] roll_value_d;
   logic              hit_d;
   logic [HP_W-1:0]   w_hp_dmg;
   logic [HP_W-1:0]   hp_d;

   // The LFSR only advances while spinning; reseeding is honoured only
   // while no roll is in flight.
   assign w_lfsr_step = (state_q == SPIN);
   assign w_lfsr_load = bus.seed_load && ((state_q == IDLE) || (state_q == KO));

   galois_lfsr #(
      .RNG_W (RNG_W),
      .SEED  (SEED),
      .TAPS  (TAPS)
   ) u_lfsr (
      .clk      (clk),
      .reset    (reset),
      .step     (w_lfsr_step),
      .load     (w_lfsr_load),
      .load_val (bus.seed),
      .state    (w_lfsr_state)
   );

   // Only the low ROLL_W bits form the roll; the rest is LFSR history
   assign w_unused_lfsr = ^w_lfsr_state;

   assign roll_value_d = w_lfsr_state[ROLL_W-1:0];
   assign hit_d        = (roll_value_d > bus.threshold);
   assign w_hp_dmg     = HP_W'(hp_sat_sub(32'(hp_q), 32'(bus.damage)));
   assign hp_d         = hit_d ? w_hp_dmg : hp_q;

   // Roll controller: IDLE -> SPIN (ROLL_W steps) -> APPLY -> IDLE or KO
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         roll_value_q <= '0;
         hit_q        <= 1'b0;
         roll_valid_q <= 1'b0;
         hp_q         <= HP_RESET;
         ko_q         <= 1'b0;
      end else begin
         roll_valid_q <= 1'b0;

         // Reload acts in every state; APPLY below skips its HP update
         if (bus.hp_reload) begin
            hp_q <= HP_RESET;
            ko_q <= 1'b0;
         end

         case (state_q)
            IDLE: begin
               if (bus.roll_req && !bus.seed_load) begin
                  state_q <= SPIN;
                  cnt_q   <= '0;
               end
            end
            SPIN: begin
               if (cnt_q == CNT_LAST) begin
                  state_q <= APPLY;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            APPLY: begin
               roll_value_q <= roll_value_d;
               hit_q        <= hit_d;
               roll_valid_q <= 1'b1;
               if (bus.hp_reload) begin
                  state_q <= IDLE;
               end else begin
                  hp_q <= hp_d;
                  if (hp_d == '0) begin
                     ko_q    <= 1'b1;
                     state_q <= KO;
                  end else begin
                     state_q <= IDLE;
                  end
               end
            end
            KO: begin
               if (bus.hp_reload) begin
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.roll_ready = (state_q == IDLE);
   assign bus.roll_valid = roll_valid_q;
   assign bus.roll_value = roll_value_q;
   assign bus.hit        = hit_q;
   assign bus.hp         = hp_q;
   assign bus.ko         = ko_q;

endmodule
`default_nettype wire
